// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues word-aligned reads to instruction memory, buffers returned words with their PCs
// in a DEPTH-entry prefetch FIFO, and presents them to decode over valid/ready.
// A redirect flushes the FIFO, drops in-flight responses and restarts at the new PC.
// Optional build macro FETCH_BYPASS_EN: an empty FIFO forwards a live response
// combinationally to the INST_* outputs in the same cycle.

module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ_VALID,
  input  logic        IMEM_REQ_READY,
  output logic [31:0] IMEM_REQ_ADDR,
  input  logic        IMEM_RESP_VALID,
  input  logic [31:0] IMEM_RESP_DATA,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic [31:0] INST_DATA,
  output logic [31:0] INST_PC
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW:0] CreditMax = (CntW + 1)'(DEPTH);

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

  // Each entry holds {pc, instruction}.
  logic [63:0]     fifo_mem [DEPTH];

  logic [CntW:0]   credit_used;
  logic            fifo_empty;
  logic            req_fire;
  logic            resp_run;
  logic            bypass;
  logic            push;
  logic            pop;

  assign fifo_empty  = (occ_q == '0);
  assign credit_used = {1'b0, occ_q} + {1'b0, outst_q};

  // A response is live (kept) only in RUN and not in a redirect cycle.
  assign resp_run = IMEM_RESP_VALID && (state_q == StRun) && !REDIRECT_VALID && !RST;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_run && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // Slots are reserved per request, so a live response is never refused.
  assign push = resp_run && !(bypass && INST_READY);
  assign pop  = INST_VALID && INST_READY && !fifo_empty;

  // Request side: credit check against FIFO space plus in-flight requests.
  always_comb begin
    IMEM_REQ_VALID = !RST && (state_q == StRun) && (credit_used < CreditMax) && !REDIRECT_VALID;
    IMEM_REQ_ADDR  = fetch_pc_q;
  end

  assign req_fire = IMEM_REQ_VALID && IMEM_REQ_READY;

  // Decode-side outputs: FIFO head, or the live response when bypass is built in.
  always_comb begin
    INST_VALID = 1'b0;
    INST_DATA  = '0;
    INST_PC    = '0;
    if (!RST) begin
      if (!fifo_empty) begin
        INST_VALID         = 1'b1;
        {INST_PC, INST_DATA} = fifo_mem[rd_ptr_q];
      end
`ifdef FETCH_BYPASS_EN
      else if (resp_run) begin
        INST_VALID = 1'b1;
        INST_DATA  = IMEM_RESP_DATA;
        INST_PC    = resp_pc_q;
      end
`endif
    end
  end

  // Next-state logic; a redirect overrides all other updates in its cycle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    occ_d      = occ_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (REDIRECT_VALID) begin
      fetch_pc_d = REDIRECT_PC & ~32'h3;
      resp_pc_d  = REDIRECT_PC & ~32'h3;
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // The response landing this cycle is dropped here; the rest drain in FLUSH.
      drop_d     = outst_q - CntW'(IMEM_RESP_VALID);
      outst_d    = outst_q - CntW'(IMEM_RESP_VALID);
      state_d    = (drop_d != '0) ? StFlush : StRun;
    end else if (state_q == StRun) begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (req_fire && !IMEM_RESP_VALID) begin
        outst_d = outst_q + CntW'(1);
      end else if (!req_fire && IMEM_RESP_VALID) begin
        outst_d = outst_q - CntW'(1);
      end
      if (IMEM_RESP_VALID) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        occ_d = occ_q + CntW'(1);
      end else if (pop && !push) begin
        occ_d = occ_q - CntW'(1);
      end
    end else begin
      if (IMEM_RESP_VALID) begin
        outst_d = outst_q - CntW'(1);
        drop_d  = drop_q - CntW'(1);
        if (drop_q == CntW'(1)) begin
          state_d = StRun;
        end
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      occ_q      <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      occ_q      <= occ_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are qualified by occupancy, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {resp_pc_q, IMEM_RESP_DATA};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a fixed-latency in-order memory model.
// Table-driven per-cycle vectors for streaming and backpressure, then hand-written
// sequences for redirect, redirect-during-flush and mid-operation reset.

module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int First = 1;
`else
  localparam int First = 2;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REDIRECT_VALID = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        IMEM_REQ_VALID;
  logic        IMEM_REQ_READY = 1'b1;
  logic [31:0] IMEM_REQ_ADDR;
  logic        IMEM_RESP_VALID = 1'b0;
  logic [31:0] IMEM_RESP_DATA = '0;
  logic        INST_VALID;
  logic        INST_READY = 1'b1;
  logic [31:0] INST_DATA;
  logic [31:0] INST_PC;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC),
    .IMEM_REQ_VALID (IMEM_REQ_VALID),
    .IMEM_REQ_READY (IMEM_REQ_READY),
    .IMEM_REQ_ADDR  (IMEM_REQ_ADDR),
    .IMEM_RESP_VALID(IMEM_RESP_VALID),
    .IMEM_RESP_DATA (IMEM_RESP_DATA),
    .INST_VALID     (INST_VALID),
    .INST_READY     (INST_READY),
    .INST_DATA      (INST_DATA),
    .INST_PC        (INST_PC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        rst_before;
    logic        inst_ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_inst_valid;
    logic [31:0] exp_inst_pc;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] deliv[$];
  vec_t        vt[20];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        s_req_valid, s_inst_valid;
  logic [31:0] s_req_addr, s_inst_pc;

  function automatic logic [31:0] dof(input logic [31:0] a);
    return a ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive the memory response, sample just before the edge, advance.
  task automatic cycle();
    mreq_t r;
    if (!RST && mq.size() > 0 && mq[0].due <= cyc) begin
      IMEM_RESP_VALID = 1'b1;
      IMEM_RESP_DATA  = dof(mq[0].addr);
    end else begin
      IMEM_RESP_VALID = 1'b0;
      IMEM_RESP_DATA  = '0;
    end
    #7;
    s_req_valid  = IMEM_REQ_VALID;
    s_req_addr   = IMEM_REQ_ADDR;
    s_inst_valid = INST_VALID;
    s_inst_pc    = INST_PC;
    if (IMEM_REQ_VALID && IMEM_REQ_READY) begin
      r.addr = IMEM_REQ_ADDR;
      r.due  = cyc + lat;
      mq.push_back(r);
    end
    if (IMEM_RESP_VALID) void'(mq.pop_front());
    if (INST_VALID && INST_READY) begin
      deliv.push_back(INST_PC);
      chk("inst_data", INST_DATA, dof(INST_PC));
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int l);
    RST = 1'b1;
    REDIRECT_VALID = 1'b0;
    IMEM_REQ_READY = 1'b1;
    INST_READY = 1'b1;
    mq.delete();
    deliv.delete();
    lat = l;
    cycle();
    cycle();
    RST = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_deliv(input int n, input string name);
    for (int i = 0; i < 30 && deliv.size() < n; i++) cycle();
    chk(name, 32'(deliv.size()), 32'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Streaming from reset with READY high, then FIFO fill under INST_READY=0.
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{i == 0, 1'b1, 1'b1, 32'(4 * i), i >= First,
                (i >= First) ? 32'(4 * (i - First)) : 32'h0};
    end
    for (int j = 0; j < 12; j++) begin
      vt[8 + j] = '{j == 0, j >= 6, (j <= 3) || (j >= 7),
                    (j <= 3) ? 32'(4 * j) : 32'(16 + 4 * (j - 7)),
                    j >= First, (j <= 6) ? 32'h0 : 32'(4 * (j - 6))};
    end

    @(posedge CLK);
    #1;
    // Outputs while reset is held.
    chk("rst_req_valid", {31'b0, IMEM_REQ_VALID}, 32'h0);
    chk("rst_req_addr", IMEM_REQ_ADDR, 32'h0);
    chk("rst_inst_valid", {31'b0, INST_VALID}, 32'h0);
    chk("rst_inst_pc", INST_PC, 32'h0);

    for (int k = 0; k < 20; k++) begin
      if (vt[k].rst_before) do_reset(1);
      INST_READY = vt[k].inst_ready;
      cycle();
      chk($sformatf("vec%0d_req_valid", k), {31'b0, s_req_valid}, {31'b0, vt[k].exp_req_valid});
      if (vt[k].exp_req_valid)
        chk($sformatf("vec%0d_req_addr", k), s_req_addr, vt[k].exp_req_addr);
      chk($sformatf("vec%0d_inst_valid", k), {31'b0, s_inst_valid}, {31'b0, vt[k].exp_inst_valid});
      if (vt[k].exp_inst_valid)
        chk($sformatf("vec%0d_inst_pc", k), s_inst_pc, vt[k].exp_inst_pc);
    end

    // Redirect with 3 requests outstanding; target low bits ignored.
    do_reset(4);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("r1_req_addr", s_req_addr, 32'(4 * i));
    end
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = 32'h103;
    cycle();
    chk("r1_req_blocked", {31'b0, s_req_valid}, 32'h0);
    REDIRECT_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("r1_flush_req", {31'b0, s_req_valid}, 32'h0);
      chk("r1_flush_inst", {31'b0, s_inst_valid}, 32'h0);
    end
    cycle();
    chk("r1_restart_valid", {31'b0, s_req_valid}, 32'h1);
    chk("r1_restart_addr", s_req_addr, 32'h100);
    wait_deliv(1, "r1_deliv_count");
    chk("r1_first_pc", deliv[0], 32'h100);

    // Redirect coinciding with a response and a pop.
    do_reset(2);
    for (int i = 0; i < 4; i++) cycle();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = 32'h300;
    cycle();
    REDIRECT_VALID = 1'b0;
    chk("r2_req_blocked", {31'b0, s_req_valid}, 32'h0);
    chk("r2_deliv_count", 32'(deliv.size()), 32'd2);
    chk("r2_pc0", deliv[0], 32'h0);
    chk("r2_pc1", deliv[1], 32'h4);
    cycle();
    chk("r2_flush_req", {31'b0, s_req_valid}, 32'h0);
    cycle();
    chk("r2_restart_valid", {31'b0, s_req_valid}, 32'h1);
    chk("r2_restart_addr", s_req_addr, 32'h300);
    wait_deliv(3, "r2_deliv_after");
    chk("r2_pc2", deliv[2], 32'h300);

    // Second redirect while flushing.
    do_reset(4);
    for (int i = 0; i < 3; i++) cycle();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = 32'h100;
    cycle();
    REDIRECT_VALID = 1'b0;
    cycle();
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC = 32'h200;
    cycle();
    REDIRECT_VALID = 1'b0;
    chk("r3_req_blocked", {31'b0, s_req_valid}, 32'h0);
    cycle();
    chk("r3_flush_req", {31'b0, s_req_valid}, 32'h0);
    cycle();
    chk("r3_restart_valid", {31'b0, s_req_valid}, 32'h1);
    chk("r3_restart_addr", s_req_addr, 32'h200);
    wait_deliv(3, "r3_deliv_count");
    for (int i = 0; i < 3; i++) chk("r3_pc", deliv[i], 32'(32'h200 + 4 * i));

    // Reset asserted mid-cycle with 2 requests outstanding and a valid instruction.
    do_reset(2);
    INST_READY = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    IMEM_REQ_READY = 1'b0;
    #2;
    chk("mr_pre_inst_valid", {31'b0, INST_VALID}, 32'h1);
    chk("mr_pre_req_addr", IMEM_REQ_ADDR, 32'hC);
    RST = 1'b1;
    #1;
    chk("mr_req_valid", {31'b0, IMEM_REQ_VALID}, 32'h0);
    chk("mr_req_addr", IMEM_REQ_ADDR, 32'h0);
    chk("mr_inst_valid", {31'b0, INST_VALID}, 32'h0);
    chk("mr_inst_data", INST_DATA, 32'h0);
    chk("mr_inst_pc", INST_PC, 32'h0);
    do_reset(2);
    cycle();
    chk("mr_restart_valid", {31'b0, s_req_valid}, 32'h1);
    chk("mr_restart_addr", s_req_addr, 32'h0);
    wait_deliv(1, "mr_deliv_count");
    chk("mr_first_pc", deliv[0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
